// File: rtl/sa_feeder.sv
// rtl/sa_feeder.sv - systolic array operand feeder with diagonal skew and pass framing
// Accepts one K-step (X column, W row) per handshake and frames each pass with start/end flags.
module sa_feeder #(
  parameter int D_W    = 8,
  parameter int SA_R   = 16,
  parameter int SA_C   = 16,
  parameter int K_W    = 8,
  parameter int PE_LAT = 1
) (
  input  logic                       I_CLK,
  input  logic                       I_RST,
  input  logic                       I_START,
  input  logic [K_W-1:0]             I_K,
  input  logic                       I_VLD,
  input  logic [0:SA_R-1][D_W-1:0]   I_X_COL,
  input  logic [0:SA_C-1][D_W-1:0]   I_W_ROW,
  output logic                       O_RDY,
  output logic                       O_START_FLAG,
  output logic                       O_END_FLAG,
  output logic [0:SA_R-1][D_W-1:0]   O_X,
  output logic [0:SA_C-1][D_W-1:0]   O_W,
  output logic                       O_BUSY
);

  localparam int DRN  = SA_R + SA_C - 1 + PE_LAT;
  localparam int DC_W = $clog2(SA_R + SA_C + PE_LAT + 1);
  localparam logic [DC_W-1:0] DRN_LAST = DC_W'(DRN - 1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_END} state_t;

  state_t          r_state;
  logic [K_W-1:0]  r_k;
  logic [K_W-1:0]  r_cnt;
  logic [DC_W-1:0] r_dcnt;
  logic            w_acc;
  logic [K_W-1:0]  w_cnt_nxt;

  // O_RDY is only ever high in FEED, so it alone qualifies an accept.
  assign w_acc     = I_VLD & O_RDY;
  assign w_cnt_nxt = r_cnt + K_W'(1);

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_cnt        <= '0;
      r_dcnt       <= '0;
      O_RDY        <= 1'b0;
      O_START_FLAG <= 1'b0;
      O_END_FLAG   <= 1'b0;
      O_BUSY       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          O_END_FLAG <= 1'b0;
          if (I_START) begin
            r_k          <= I_K;
            r_cnt        <= '0;
            r_state      <= S_FEED;
            O_START_FLAG <= 1'b1;
            O_RDY        <= (I_K != '0);
            O_BUSY       <= 1'b1;
          end
        end
        S_FEED: begin
          O_START_FLAG <= 1'b0;
          if (r_k == '0) begin
            r_state <= S_DRAIN;
            r_dcnt  <= '0;
            O_RDY   <= 1'b0;
          end else if (w_acc) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_k) begin
              r_state <= S_DRAIN;
              r_dcnt  <= '0;
              O_RDY   <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (r_dcnt == DRN_LAST) begin
            r_state    <= S_END;
            O_END_FLAG <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + DC_W'(1);
          end
        end
        S_END: begin
          O_END_FLAG <= 1'b0;
          O_BUSY     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Lane n is an (n+1)-deep shift register; non-accept cycles push zero bubbles.
  for (genvar i = 0; i < SA_R; i++) begin : g_x
    logic [D_W-1:0] r_sh [0:i];
    always_ff @(posedge I_CLK) begin
      if (I_RST) begin
        for (int s = 0; s <= i; s++) r_sh[s] <= '0;
      end else begin
        r_sh[0] <= w_acc ? I_X_COL[i] : '0;
        for (int s = 1; s <= i; s++) r_sh[s] <= r_sh[s-1];
      end
    end
    assign O_X[i] = r_sh[i];
  end

  for (genvar j = 0; j < SA_C; j++) begin : g_w
    logic [D_W-1:0] r_sh [0:j];
    always_ff @(posedge I_CLK) begin
      if (I_RST) begin
        for (int s = 0; s <= j; s++) r_sh[s] <= '0;
      end else begin
        r_sh[0] <= w_acc ? I_W_ROW[j] : '0;
        for (int s = 1; s <= j; s++) r_sh[s] <= r_sh[s-1];
      end
    end
    assign O_W[j] = r_sh[j];
  end

endmodule

// File: tb/tb_sa_feeder.sv
// tb/tb_sa_feeder.sv - directed self-checking bench for sa_feeder
// Small 2x2 array, PE_LAT=1; cycle c0 is the cycle I_START is presented.
module tb_sa_feeder;
  localparam int D_W = 8, SA_R = 2, SA_C = 2, K_W = 8, PE_LAT = 1;

  logic                     clk = 1'b0;
  logic                     i_rst, i_start, i_vld;
  logic [K_W-1:0]           i_k;
  logic [0:SA_R-1][D_W-1:0] x_col, o_x;
  logic [0:SA_C-1][D_W-1:0] w_row, o_w;
  logic                     o_rdy, o_sf, o_ef, o_busy;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] t_x0 [0:31];
  logic [7:0] t_x1 [0:31];
  logic [7:0] t_w0 [0:31];
  logic [7:0] t_w1 [0:31];
  logic       t_sf [0:31];
  logic       t_ef [0:31];
  logic       t_busy [0:31];
  logic       t_rdy [0:31];

  always #5 clk = ~clk;

  sa_feeder #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .K_W(K_W), .PE_LAT(PE_LAT)) dut (
    .I_CLK(clk), .I_RST(i_rst), .I_START(i_start), .I_K(i_k), .I_VLD(i_vld),
    .I_X_COL(x_col), .I_W_ROW(w_row), .O_RDY(o_rdy), .O_START_FLAG(o_sf),
    .O_END_FLAG(o_ef), .O_X(o_x), .O_W(o_w), .O_BUSY(o_busy)
  );

  // Step s carries X={2s+1,2s+2}, W={2s+7,2s+8}.
  task automatic drive_step(input int s);
    x_col[0] = 8'(2*s + 1);
    x_col[1] = 8'(2*s + 2);
    w_row[0] = 8'(2*s + 7);
    w_row[1] = 8'(2*s + 8);
  endtask

  task automatic run_pass(input int k, input int ncyc, input logic [31:0] vld_low,
                          input logic [31:0] st_mask, input logic [31:0] rst_mask);
    int idx;
    idx = 0;
    i_start = 1'b1;
    i_k = 8'(k);
    i_vld = 1'b1;
    drive_step(0);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      t_x0[c] = o_x[0]; t_x1[c] = o_x[1];
      t_w0[c] = o_w[0]; t_w1[c] = o_w[1];
      t_sf[c] = o_sf; t_ef[c] = o_ef; t_busy[c] = o_busy; t_rdy[c] = o_rdy;
      i_start = st_mask[c];
      i_rst = rst_mask[c];
      i_vld = !vld_low[c];
      drive_step(idx);
      if (i_vld && o_rdy && !i_rst) idx++;
    end
    i_start = 1'b0;
    i_vld = 1'b0;
    i_rst = 1'b0;
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_start = 1'b0; i_vld = 1'b1; i_k = 8'd5;
    drive_step(4);
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_chk++;
      if ({o_x, o_w, o_sf, o_ef, o_busy, o_rdy} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle c%0d: x=%h w=%h sf=%b ef=%b busy=%b rdy=%b, expected all 0",
                 c, o_x, o_w, o_sf, o_ef, o_busy, o_rdy);
      end
    end
    i_vld = 1'b0;
  endtask

  task automatic test_basic;
    logic [7:0] e_x0 [1:10];
    logic [7:0] e_x1 [1:10];
    logic [7:0] e_w0 [1:10];
    logic [7:0] e_w1 [1:10];
    e_x0 = '{0, 1, 3, 5, 0, 0, 0, 0, 0, 0};
    e_x1 = '{0, 0, 2, 4, 6, 0, 0, 0, 0, 0};
    e_w0 = '{0, 7, 9, 11, 0, 0, 0, 0, 0, 0};
    e_w1 = '{0, 0, 8, 10, 12, 0, 0, 0, 0, 0};
    run_pass(3, 10, 32'h0, 32'h0, 32'h0);
    for (int c = 1; c <= 10; c++) begin
      n_chk++;
      if ({t_x0[c], t_x1[c], t_w0[c], t_w1[c]} !== {e_x0[c], e_x1[c], e_w0[c], e_w1[c]}) begin
        n_fail++;
        $display("FAIL basic_lanes c%0d: x0=%0d x1=%0d w0=%0d w1=%0d, expected %0d %0d %0d %0d",
                 c, t_x0[c], t_x1[c], t_w0[c], t_w1[c], e_x0[c], e_x1[c], e_w0[c], e_w1[c]);
      end
      n_chk++;
      if ({t_sf[c], t_ef[c], t_busy[c], t_rdy[c]} !== {c == 1, c == 8, c <= 8, c <= 3}) begin
        n_fail++;
        $display("FAIL basic_flags c%0d: sf/ef/busy/rdy=%b%b%b%b, expected %b%b%b%b", c,
                 t_sf[c], t_ef[c], t_busy[c], t_rdy[c], c == 1, c == 8, c <= 8, c <= 3);
      end
    end
  endtask

  task automatic test_stall;
    logic [7:0] e_x0 [1:11];
    logic [7:0] e_x1 [1:11];
    logic [7:0] e_w0 [1:11];
    logic [7:0] e_w1 [1:11];
    e_x0 = '{0, 1, 0, 3, 5, 0, 0, 0, 0, 0, 0};
    e_x1 = '{0, 0, 2, 0, 4, 6, 0, 0, 0, 0, 0};
    e_w0 = '{0, 7, 0, 9, 11, 0, 0, 0, 0, 0, 0};
    e_w1 = '{0, 0, 8, 0, 10, 12, 0, 0, 0, 0, 0};
    run_pass(3, 11, 32'h4, 32'h0, 32'h0);
    for (int c = 1; c <= 11; c++) begin
      n_chk++;
      if ({t_x0[c], t_x1[c], t_w0[c], t_w1[c]} !== {e_x0[c], e_x1[c], e_w0[c], e_w1[c]}) begin
        n_fail++;
        $display("FAIL stall_lanes c%0d: x0=%0d x1=%0d w0=%0d w1=%0d, expected %0d %0d %0d %0d",
                 c, t_x0[c], t_x1[c], t_w0[c], t_w1[c], e_x0[c], e_x1[c], e_w0[c], e_w1[c]);
      end
      n_chk++;
      if ({t_sf[c], t_ef[c], t_busy[c], t_rdy[c]} !== {c == 1, c == 9, c <= 9, c <= 4}) begin
        n_fail++;
        $display("FAIL stall_flags c%0d: sf/ef/busy/rdy=%b%b%b%b, expected %b%b%b%b", c,
                 t_sf[c], t_ef[c], t_busy[c], t_rdy[c], c == 1, c == 9, c <= 9, c <= 4);
      end
    end
  endtask

  task automatic test_k0;
    run_pass(0, 8, 32'h0, 32'h0, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      n_chk++;
      if ({t_x0[c], t_x1[c], t_w0[c], t_w1[c], t_rdy[c]} !== 33'd0) begin
        n_fail++;
        $display("FAIL k0_lanes c%0d: x0=%0d x1=%0d w0=%0d w1=%0d rdy=%b, expected all 0",
                 c, t_x0[c], t_x1[c], t_w0[c], t_w1[c], t_rdy[c]);
      end
      n_chk++;
      if ({t_sf[c], t_ef[c], t_busy[c]} !== {c == 1, c == 6, c <= 6}) begin
        n_fail++;
        $display("FAIL k0_flags c%0d: sf/ef/busy=%b%b%b, expected %b%b%b", c,
                 t_sf[c], t_ef[c], t_busy[c], c == 1, c == 6, c <= 6);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n_sf, n_ef;
    n_sf = 0;
    n_ef = 0;
    // Pulses in FEED (c3) and DRAIN (c6) are ignored; held across END (c8..c9) restarts.
    run_pass(3, 20, 32'h0, 32'h348, 32'h0);
    for (int c = 1; c <= 20; c++) begin
      n_sf += int'(t_sf[c]);
      n_ef += int'(t_ef[c]);
      n_chk++;
      if ({t_sf[c], t_ef[c], t_busy[c]} !== {c == 1 || c == 10, c == 8 || c == 17, !(c == 9 || c >= 18)}) begin
        n_fail++;
        $display("FAIL b2b_flags c%0d: sf/ef/busy=%b%b%b, expected %b%b%b", c, t_sf[c], t_ef[c],
                 t_busy[c], c == 1 || c == 10, c == 8 || c == 17, !(c == 9 || c >= 18));
      end
    end
    n_chk++;
    if (n_sf != 2 || n_ef != 2) begin
      n_fail++;
      $display("FAIL b2b_pulse_count: start=%0d end=%0d, expected 2 and 2", n_sf, n_ef);
    end
  endtask

  task automatic test_reset_mid;
    run_pass(3, 8, 32'h0, 32'h0, 32'h8);
    n_chk++;
    if ({t_x0[3], t_x1[3], t_busy[3]} !== {8'd3, 8'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL rstmid_pre c3: x0=%0d x1=%0d busy=%b, expected 3 2 1", t_x0[3], t_x1[3], t_busy[3]);
    end
    for (int c = 4; c <= 8; c++) begin
      n_chk++;
      if ({t_x0[c], t_x1[c], t_w0[c], t_w1[c], t_sf[c], t_ef[c], t_busy[c], t_rdy[c]} !== 36'd0) begin
        n_fail++;
        $display("FAIL rstmid_clear c%0d: x0=%0d x1=%0d w0=%0d w1=%0d sf/ef/busy/rdy=%b%b%b%b, expected all 0",
                 c, t_x0[c], t_x1[c], t_w0[c], t_w1[c], t_sf[c], t_ef[c], t_busy[c], t_rdy[c]);
      end
    end
    test_basic();
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_vld = 1'b0; i_k = '0;
    x_col = '0; w_row = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_k0();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sa_feeder.md
Name: sa_feeder

Overview:
- Transmit-side companion to the systolic array (SA).
- Accepts one K-step of operands per handshake: a column of X (SA_R values) and a row of W (SA_C values).
- Applies the diagonal skew the array needs: row i delayed by i cycles, column j delayed by j cycles.
- Frames each matrix pass with the SA's start and end flags, including the zero-fill drain.
- Sits between the operand buffers and the SA; its outputs connect directly to the SA's I_START_FLAG, I_END_FLAG, I_X and I_W.

Parameters:
- D_W, 8, operand width in bits (fixed point 1 sign / 2 int / rest fraction; passed through untouched).
- SA_R, 16, array rows; number of X lanes.
- SA_C, 16, array columns; number of W lanes.
- K_W, 8, width of the K (inner-dimension length) field.
- PE_LAT, 1, extra drain cycles covering PE output registering.

Ports:
- I_CLK, in, 1, clock.
- I_RST, in, 1, reset. Synchronous, active-high.
- I_START, in, 1, pass request; sampled only in IDLE.
- I_K, in, K_W, number of operand steps in the pass; latched on an accepted I_START.
- I_VLD, in, 1, upstream operand step valid.
- I_X_COL, in, D_W x [0:SA_R-1], X column for the current step.
- I_W_ROW, in, D_W x [0:SA_C-1], W row for the current step.
- O_RDY, out, 1, feeder ready to accept a step.
- O_START_FLAG, out, 1, drives SA I_START_FLAG.
- O_END_FLAG, out, 1, drives SA I_END_FLAG.
- O_X, out, D_W x [0:SA_R-1], skewed X lanes to the SA.
- O_W, out, D_W x [0:SA_C-1], skewed W lanes to the SA.
- O_BUSY, out, 1, high whenever state is not IDLE.

Behaviour:
- States: IDLE, FEED, DRAIN, END. All outputs registered.
- Reset: state IDLE; every delay stage cleared; O_X, O_W all zero; O_RDY, O_START_FLAG, O_END_FLAG, O_BUSY all 0. Reset mid-pass aborts immediately with no END pulse.
- IDLE + I_START (cycle c0):
  - Latch I_K into k_r.
  - Cycle c1: O_START_FLAG=1 for exactly one cycle, state=FEED, O_RDY=1.
  - I_START outside IDLE is ignored.
- FEED:
  - O_RDY=1. A step is accepted on an edge with I_VLD & O_RDY.
  - Accepted step count cnt goes 0..k_r; leave FEED on the edge that accepts step k_r (O_RDY low from the next cycle).
  - k_r=0: go FEED->DRAIN after c1 with no accept.
- Skew pipeline:
  - A step accepted at the edge ending cycle t drives O_X[i]=I_X_COL[i] in cycle t+1+i and O_W[j]=I_W_ROW[j] in cycle t+1+j.
  - Lane 0 has one register stage; lane n has n+1 stages.
  - A cycle with no accept (stall, DRAIN, END, IDLE) injects zero into all lane heads. Stalls therefore insert aligned zero bubbles, which add nothing to the accumulators.
- DRAIN:
  - Counter runs SA_R+SA_C-1+PE_LAT cycles from the edge of the last accept (or from c1 when k_r=0).
  - Then state END.
  - O_END_FLAG=1 in cycle cL+SA_R+SA_C+PE_LAT, where cL is the last-accept cycle.
- END: O_END_FLAG pulses one cycle; next cycle state IDLE, O_BUSY=0. A new I_START may be sampled in that IDLE cycle.
- Width rules: no arithmetic on data. The counters are K_W bits and ceil(log2(SA_R+SA_C+PE_LAT+1)) bits. cnt compares equal to k_r and never wraps; k_r=2^K_W-1 is legal.

Test Plan:
1. Reset then idle, 20 cycles -> O_X/O_W all 0, all flags 0, O_BUSY 0; I_VLD=1 while idle gives no accept (O_RDY=0).
2. SA_R=SA_C=2, PE_LAT=1, K=3, steps X={1,2},{3,4},{5,6}, W={7,8},{9,10},{11,12}, I_VLD always high:
   - O_START_FLAG in c1.
   - O_X[0] = 1,3,5 in c2..c4; O_X[1] = 2,4,6 in c3..c5.
   - O_W[0] = 7,9,11 in c2..c4; O_W[1] = 8,10,12 in c3..c5.
   - O_END_FLAG in c3+2+2+1 = c8; O_BUSY low in c9.
3. Same as scenario 2 with I_VLD low in c2 -> zero bubble on lane 0 in c3 and on lane 1 in c4; remaining data shifted one cycle later; O_END_FLAG in c9.
4. K=0 -> O_START_FLAG in c1, no accepts, O_END_FLAG at c1+SA_R+SA_C+PE_LAT, all lanes zero throughout.
5. I_START pulsed during FEED and DRAIN -> ignored; exactly one START pulse and one END pulse per pass; back-to-back pass starts when I_START is held across the END cycle.
6. I_RST asserted mid-FEED with data in the lanes -> next cycle all outputs zero, state IDLE, no O_END_FLAG; a following pass behaves exactly as scenario 2.
